// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM state encoding (IDLE, FETCH, HOLD)
//   WORD_BYTES    : size of one instruction word in bytes
//   PC_WIDTH      : program counter / address width
//   word_align()  : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC selection for the fetch unit.
//   instr_pc   in  : address of the instruction being retired
//   pc_src     in  : retiring instruction redirects the PC
//   pc_target  in  : redirect address (may be misaligned)
//   next_pc    out : word-aligned address of the next fetch
//   misaligned out : redirect requested with pc_target[1:0] != 0
module pc_next
  import fetch_pkg::*;
(
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                pc_src,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                misaligned
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(WORD_BYTES);

  // Sequential increment wraps naturally modulo 2^32.
  assign next_pc    = pc_src ? word_align(pc_target) : instr_pc + STEP;
  assign misaligned = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit for the ARM-subset core.
// Owns the PC, fetches one word at a time over a req/ack handshake and
// presents it to the consumer until retired; applies branch redirects
// at retire time.
//   clk, reset            : clock, asynchronous active-high reset
//   imem_req/imem_addr    : read request and word address (registered)
//   imem_ack/imem_rdata   : read completion and data from memory
//   instr_valid/instr     : live instruction and its word
//   instr_pc/pc_plus8     : its address and address+8 (R15 view)
//   instr_ready           : consumer retires the instruction
//   pc_src/pc_target      : redirect request, sampled on retire
//   align_fault           : one-cycle pulse for a misaligned redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] pc_plus8,
  input  logic                instr_ready,
  input  logic                pc_src,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic                align_fault
);

  localparam logic [PC_WIDTH-1:0] R15_OFFSET = PC_WIDTH'(2 * WORD_BYTES);

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] next_pc;
  logic                misaligned;
  logic                accept;
  logic                retire;

  assign accept = (state_q == FETCH) && imem_ack;
  assign retire = (state_q == HOLD) && instr_ready;

  pc_next u_pc_next (
    .instr_pc   (instr_pc),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack)    state_d = HOLD;
      HOLD:    if (instr_ready) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; req/valid are registered copies of the
  // next state so they change exactly on the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      align_fault <= 1'b0;
      pc_q        <= RESET_PC;
      instr       <= '0;
      instr_pc    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      imem_req    <= (state_d == FETCH);
      instr_valid <= (state_d == HOLD);
      align_fault <= retire && misaligned;
      // The fetch address moves only on retire, so it is stable for the
      // whole time a request is outstanding.
      if (retire) begin
        pc_q <= next_pc;
      end
      if (accept) begin
        instr    <= imem_rdata;
        instr_pc <= pc_q;
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc_plus8  = instr_pc + R15_OFFSET;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  // main instance, RESET_PC = 0
  logic        imem_req, imem_ack, instr_valid, instr_ready, pc_src, align_fault;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc_plus8, pc_target;
  // wrap instance, RESET_PC = 0xFFFF_FFFC, zero-wait memory
  logic        req1, ack1, valid1, ready1, fault1;
  logic [31:0] addr1, rdata1, instr1, ipc1, plus8_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_plus8(pc_plus8), .instr_ready(instr_ready),
    .pc_src(pc_src), .pc_target(pc_target), .align_fault(align_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rdata1),
    .instr_valid(valid1), .instr(instr1), .instr_pc(ipc1),
    .pc_plus8(plus8_1), .instr_ready(ready1),
    .pc_src(1'b0), .pc_target(32'h0000_0000), .align_fault(fault1)
  );

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A0_1005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign ack1   = req1;
  assign rdata1 = memword(addr1);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: expected visible outputs for the current cycle.
  logic        e_start, e_req, e_valid, e_fault;
  logic [31:0] e_addr, e_ipc, e_instr;
  // memory / stimulus state
  logic        pend, first_req, hold, prev_unack;
  int          wcnt, cyc;
  logic [31:0] prev_addr;

  task automatic init_model();
    e_start = 1'b1; e_req = 1'b0; e_valid = 1'b0; e_fault = 1'b0;
    e_addr = 32'h0; e_ipc = 32'h0; e_instr = 32'h0;
    pend = 1'b0; prev_unack = 1'b0;
  endtask

  task automatic check_reset_vals(input string sfx);
    chk({"rst_req", sfx},   {31'b0, imem_req},    32'h0);
    chk({"rst_addr", sfx},  imem_addr,            32'h0);
    chk({"rst_valid", sfx}, {31'b0, instr_valid}, 32'h0);
    chk({"rst_instr", sfx}, instr,                32'h0);
    chk({"rst_ipc", sfx},   instr_pc,             32'h0);
    chk({"rst_plus8", sfx}, pc_plus8,             32'h8);
    chk({"rst_fault", sfx}, {31'b0, align_fault}, 32'h0);
  endtask

  // Advance the model one clock using the inputs applied this cycle.
  task automatic step_model();
    if (e_start) begin
      e_start = 1'b0;
      e_req   = 1'b1;
      e_fault = 1'b0;
    end else if (e_req && imem_ack) begin
      e_req   = 1'b0;
      e_valid = 1'b1;
      e_ipc   = e_addr;
      e_instr = memword(e_addr);
      e_fault = 1'b0;
    end else if (e_valid && instr_ready) begin
      e_valid = 1'b0;
      e_req   = 1'b1;
      e_addr  = pc_src ? (pc_target & 32'hFFFF_FFFC) : e_ipc + 32'd4;
      e_fault = pc_src && (pc_target % 4 != 0);
    end else begin
      e_fault = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("req",   {31'b0, imem_req},    {31'b0, e_req});
    chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
    chk("fault", {31'b0, align_fault}, {31'b0, e_fault});
    chk("ipc",   instr_pc,             e_ipc);
    chk("instr", instr,                e_instr);
    chk("plus8", pc_plus8,             e_ipc + 32'd8);
    if (e_req) chk("addr", imem_addr, e_addr);
    if (prev_unack) begin
      chk("req_held",  {31'b0, imem_req}, 32'h1);
      chk("addr_held", imem_addr,         prev_addr);
    end
  endtask

  task automatic drive();
    logic [31:0] r;
    r = $urandom;
    pc_src = (r % 3) == 0;
    case ($urandom % 4)
      0:       pc_target = 32'h0000_0040;
      1:       pc_target = 32'h0000_0043;
      2:       pc_target = $urandom & 32'h0000_0FFF;
      default: pc_target = $urandom;
    endcase
    if (hold) begin
      instr_ready = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
    end else begin
      instr_ready = ($urandom % 5) < 2;
      if (imem_req) begin
        if (!pend) begin
          pend = 1'b1;
          wcnt = first_req ? 2 : int'($urandom % 4);
          first_req = 1'b0;
        end
        if (wcnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memword(imem_addr);
          pend       = 1'b0;
        end else begin
          wcnt--;
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
        end
      end else begin
        imem_ack   = ($urandom % 4) == 0;  // spurious, must be ignored
        imem_rdata = $urandom;
      end
    end
    prev_unack = imem_req && !imem_ack;
    prev_addr  = imem_addr;
  endtask

  task automatic wrap_checks();
    if (cyc == 10) begin
      chk("wrap_valid0", {31'b0, valid1}, 32'h1);
      chk("wrap_ipc0",   ipc1,            32'hFFFF_FFFC);
      chk("wrap_plus80", plus8_1,         32'h0000_0004);
      chk("wrap_instr0", instr1,          memword(32'hFFFF_FFFC));
      ready1 = 1'b1;
    end else if (cyc == 11) begin
      ready1 = 1'b0;
      chk("wrap_req",   {31'b0, req1},   32'h1);
      chk("wrap_addr",  addr1,           32'h0);
      chk("wrap_fault", {31'b0, fault1}, 32'h0);
    end else if (cyc == 12) begin
      chk("wrap_valid1", {31'b0, valid1}, 32'h1);
      chk("wrap_ipc1",   ipc1,            32'h0);
      chk("wrap_plus81", plus8_1,         32'h0000_0008);
      chk("wrap_instr1", instr1,          32'hE3A0_1005);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      compare_all();
      wrap_checks();
      drive();
      step_model();
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pc_src = 1'b0; pc_target = '0; ready1 = 1'b0;
    hold = 1'b0; first_req = 1'b1; cyc = 0; wcnt = 0;
    init_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("");
    reset = 1'b0;
    // First request after reset: no ack, no retire in this cycle.
    imem_ack = 1'b0; instr_ready = 1'b0;
    step_model();

    run_cycles(3000);

    // Reset while a request is outstanding.
    hold = 1'b1;
    run_cycles(6);
    @(posedge clk); #1;
    compare_all();
    chk("req_before_reset", {31'b0, imem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check_reset_vals("_mid");
    @(posedge clk); #1;
    check_reset_vals("_mid2");
    reset = 1'b0;
    hold = 1'b0;
    init_model();
    imem_ack = 1'b0; instr_ready = 1'b0;
    step_model();
    run_cycles(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
